// File: rtl/dpsram_ctrl_pkg.sv
// Shared definitions for the DPSRAM port A0 arbiter: output configs, FSM states, decode helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dpsram_ctrl_pkg;

  // Output width configurations of the DPSRAM block.
  localparam logic [2:0] CONFIG_1BIT  = 3'd1;
  localparam logic [2:0] CONFIG_2BIT  = 3'd2;
  localparam logic [2:0] CONFIG_5BIT  = 3'd3;
  localparam logic [2:0] CONFIG_10BIT = 3'd4;
  localparam logic [2:0] CONFIG_20BIT = 3'd5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ERR   = 2'd2
  } state_e;

  // Number of flat-address bits that stay inside one RAM; the next two bits pick the RAM.
  function automatic logic [3:0] cfg_to_shift(input logic [2:0] cfg);
    case (cfg)
      CONFIG_1BIT:  return 4'd13;
      CONFIG_2BIT:  return 4'd12;
      CONFIG_5BIT:  return 4'd11;
      CONFIG_10BIT: return 4'd10;
      default:      return 4'd9;
    endcase
  endfunction

  function automatic logic cfg_is_legal(input logic [2:0] cfg);
    return (cfg >= CONFIG_1BIT) && (cfg <= CONFIG_20BIT);
  endfunction

endpackage

// File: rtl/dpsram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant among valid requesters, pointer flips to the other side after a grant.
// Latency: grant is combinational from valid_i/enable_i; pointer updates on the next rising edge.
// Backpressure: enable_i low suppresses all grants and freezes the pointer.
//   clk_i, rst_i : clock, async active-high reset (pointer -> 0)
//   valid_i[1:0] : request valids;  enable_i : grants allowed
//   grant_o[1:0] : one-hot grant (zero when nothing granted)
module rr_arbiter2
  import dpsram_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant_o  = 2'b00;
    rr_ptr_d = rr_ptr_q;
    if (enable_i) begin
      case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = rr_ptr_q ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
      // Favour the side that was not just served.
      if (grant_o[0]) begin
        rr_ptr_d = 1'b1;
      end else if (grant_o[1]) begin
        rr_ptr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/dpsram_port_arbiter.sv
// Shares DPSRAM TDP port A0 between two requesters: round-robin grant, flat-address decode, read-data return.
// Latency: RAM strobes one cycle after handshake; read response three cycles after handshake.
// Backpressure: readies are grants (one per cycle, RUN only); config updates hold readies low until reads drain.
//   cfg_*         : output-config request/update pulse, error flag
//   req0_*/req1_* : requester valid/ready, we, flat addr, write data
//   rsp0/1_valid_o, rsp_rddata_o : read response strobes and shared data
//   ram_*         : registered strobes/select/address/data to the RAM port, read data back from deselection
module dpsram_port_arbiter
  import dpsram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 20,
  parameter int LOC_W  = 13
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        cfg_output_config_i,
  input  logic              cfg_update_i,
  output logic              cfg_error_o,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic              req0_we_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wrdata_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic              req1_we_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wrdata_i,
  output logic              rsp0_valid_o,
  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp_rddata_o,
  output logic              ram_re_o,
  output logic              ram_we_o,
  output logic [1:0]        ram_select_o,
  output logic [LOC_W-1:0]  ram_addr_o,
  output logic [DATA_W-1:0] ram_wrdata_o,
  input  logic [DATA_W-1:0] ram_rddata_i
);

  state_e            state_q, state_d;
  logic [2:0]        cfg_q, cfg_d, cfg_lat_q, cfg_lat_d;
  logic [1:0]        grant;
  logic              hs, hs_id, hs_we;
  logic [ADDR_W-1:0] hs_addr, addr_shifted, addr_mask;
  logic [DATA_W-1:0] hs_wrdata;
  logic [3:0]        shift;
  logic              p1_vld_q, p1_id_q, p2_vld_q, p2_id_q;
  logic              rsp0_q, rsp1_q;
  logic [DATA_W-1:0] rsp_rddata_q;
  logic              pipe_empty;

  rr_arbiter2 u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  ({req1_valid_i, req0_valid_i}),
    .enable_i (state_q == RUN),
    .grant_o  (grant)
  );

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];
  assign hs           = grant[0] | grant[1];
  assign hs_id        = grant[1];
  assign hs_we        = hs_id ? req1_we_i     : req0_we_i;
  assign hs_addr      = hs_id ? req1_addr_i   : req0_addr_i;
  assign hs_wrdata    = hs_id ? req1_wrdata_i : req0_wrdata_i;

  // Decode always uses the committed config; it only changes once the pipeline is empty.
  assign shift        = cfg_to_shift(cfg_q);
  assign addr_shifted = hs_addr >> shift;
  assign addr_mask    = (ADDR_W'(1) << shift) - ADDR_W'(1);

  // The response register counts as in flight so DRAIN exits only after the last rsp is presented.
  assign pipe_empty   = !p1_vld_q && !p2_vld_q && !rsp0_q && !rsp1_q;
  assign cfg_error_o  = (state_q == ERR);

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    cfg_lat_d = cfg_lat_q;
    case (state_q)
      RUN, ERR: begin
        if (cfg_update_i) begin
          state_d   = DRAIN;
          cfg_lat_d = cfg_output_config_i;
        end
      end
      DRAIN: begin
        if (cfg_update_i) begin
          cfg_lat_d = cfg_output_config_i;
        end else if (pipe_empty) begin
          cfg_d   = cfg_lat_q;
          state_d = cfg_is_legal(cfg_lat_q) ? RUN : ERR;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      cfg_q        <= CONFIG_20BIT;
      cfg_lat_q    <= CONFIG_20BIT;
      ram_re_o     <= 1'b0;
      ram_we_o     <= 1'b0;
      ram_select_o <= 2'd0;
      ram_addr_o   <= '0;
      ram_wrdata_o <= '0;
      p1_vld_q     <= 1'b0;
      p1_id_q      <= 1'b0;
      p2_vld_q     <= 1'b0;
      p2_id_q      <= 1'b0;
      rsp0_q       <= 1'b0;
      rsp1_q       <= 1'b0;
      rsp_rddata_q <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      cfg_lat_q <= cfg_lat_d;
      ram_re_o  <= hs && !hs_we;
      ram_we_o  <= hs && hs_we;
      if (hs) begin
        ram_select_o <= addr_shifted[1:0];
        ram_addr_o   <= LOC_W'(hs_addr & addr_mask);
        ram_wrdata_o <= hs_wrdata;
      end
      p1_vld_q <= hs && !hs_we;
      p1_id_q  <= hs_id;
      p2_vld_q <= p1_vld_q;
      p2_id_q  <= p1_id_q;
      rsp0_q   <= p2_vld_q && !p2_id_q;
      rsp1_q   <= p2_vld_q && p2_id_q;
      if (p2_vld_q) begin
        rsp_rddata_q <= ram_rddata_i;
      end
    end
  end

  assign rsp0_valid_o = rsp0_q;
  assign rsp1_valid_o = rsp1_q;
  assign rsp_rddata_o = rsp_rddata_q;

endmodule

// File: tb/tb_dpsram_port_arbiter.sv
// Self-checking bench for dpsram_port_arbiter: directed scenarios plus random traffic against a transaction model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_dpsram_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  cfg_output_config_i;
  logic        cfg_update_i;
  logic        cfg_error_o;
  logic        req0_valid_i, req0_ready_o, req0_we_i;
  logic [14:0] req0_addr_i;
  logic [19:0] req0_wrdata_i;
  logic        req1_valid_i, req1_ready_o, req1_we_i;
  logic [14:0] req1_addr_i;
  logic [19:0] req1_wrdata_i;
  logic        rsp0_valid_o, rsp1_valid_o;
  logic [19:0] rsp_rddata_o;
  logic        ram_re_o, ram_we_o;
  logic [1:0]  ram_select_o;
  logic [12:0] ram_addr_o;
  logic [19:0] ram_wrdata_o;
  logic [19:0] ram_rddata_i;

  int checks = 0;
  int errors = 0;

  // Transaction model: mode 0=run, 1=draining, 2=error; reads are kept as (due cycle, requester) pairs.
  int m_mode, m_cfg, m_lat, m_prefer, cyc, last_grant;
  int due_q[$];
  int id_q[$];
  int e_re, e_we, e_sel, e_addr, e_wd, e_rd;

  always #5 clk_i = ~clk_i;

  dpsram_port_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_output_config_i(cfg_output_config_i), .cfg_update_i(cfg_update_i), .cfg_error_o(cfg_error_o),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
    .req0_addr_i(req0_addr_i), .req0_wrdata_i(req0_wrdata_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
    .req1_addr_i(req1_addr_i), .req1_wrdata_i(req1_wrdata_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp1_valid_o(rsp1_valid_o), .rsp_rddata_o(rsp_rddata_o),
    .ram_re_o(ram_re_o), .ram_we_o(ram_we_o), .ram_select_o(ram_select_o),
    .ram_addr_o(ram_addr_o), .ram_wrdata_o(ram_wrdata_o), .ram_rddata_i(ram_rddata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_cfg = 5; m_lat = 5; m_prefer = 0;
    due_q.delete(); id_q.delete();
    e_re = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wd = 0; e_rd = 0;
  endtask

  function automatic int model_grant();
    if (m_mode != 0) return -1;
    if (req0_valid_i && req1_valid_i) return m_prefer;
    if (req0_valid_i) return 0;
    if (req1_valid_i) return 1;
    return -1;
  endfunction

  // One clock: check every output mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    int g, sh, addr;
    bit r0, r1, empty;
    #3;
    g = model_grant();
    chk("ready0", 32'(req0_ready_o), 32'(g == 0));
    chk("ready1", 32'(req1_ready_o), 32'(g == 1));
    chk("ram_re", 32'(ram_re_o), 32'(e_re));
    chk("ram_we", 32'(ram_we_o), 32'(e_we));
    if (e_re != 0 || e_we != 0) begin
      chk("ram_select", 32'(ram_select_o), 32'(e_sel));
      chk("ram_addr", 32'(ram_addr_o), 32'(e_addr));
    end
    chk("ram_wrdata", 32'(ram_wrdata_o), 32'(e_wd));
    r0 = 0; r1 = 0;
    foreach (due_q[i]) if (due_q[i] == cyc) begin
      if (id_q[i] == 0) r0 = 1; else r1 = 1;
    end
    chk("rsp0_valid", 32'(rsp0_valid_o), 32'(r0));
    chk("rsp1_valid", 32'(rsp1_valid_o), 32'(r1));
    chk("rsp_exclusive", 32'(rsp0_valid_o & rsp1_valid_o), 32'(0));
    chk("rsp_rddata", 32'(rsp_rddata_o), 32'(e_rd));
    chk("cfg_error", 32'(cfg_error_o), 32'(m_mode == 2));
    @(posedge clk_i);
    foreach (due_q[i]) if (due_q[i] == cyc + 1) e_rd = int'(ram_rddata_i);
    empty = (due_q.size() == 0);
    e_re = 0; e_we = 0;
    last_grant = g;
    if (g >= 0) begin
      addr = (g == 1) ? int'(req1_addr_i) : int'(req0_addr_i);
      sh = 14 - m_cfg;
      e_sel = (addr >> sh) & 3;
      e_addr = addr & ((1 << sh) - 1);
      e_wd = (g == 1) ? int'(req1_wrdata_i) : int'(req0_wrdata_i);
      if (((g == 1) ? req1_we_i : req0_we_i) == 1'b1) e_we = 1;
      else begin
        e_re = 1;
        due_q.push_back(cyc + 3);
        id_q.push_back(g);
      end
      m_prefer = 1 - g;
    end
    if (m_mode == 1) begin
      if (cfg_update_i) m_lat = int'(cfg_output_config_i);
      else if (empty) begin
        m_cfg = m_lat;
        m_mode = (m_lat >= 1 && m_lat <= 5) ? 0 : 2;
      end
    end else if (cfg_update_i) begin
      m_mode = 1;
      m_lat = int'(cfg_output_config_i);
    end
    cyc++;
    while (due_q.size() > 0 && due_q[0] < cyc) begin
      void'(due_q.pop_front());
      void'(id_q.pop_front());
    end
    #1;
    ram_rddata_i = 20'($urandom);
  endtask

  task automatic idle_reqs();
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; cfg_update_i = 1'b0;
  endtask

  // Async reset from mid-cycle: every output must drop at once, before any clock edge.
  task automatic do_reset();
    idle_reqs();
    rst_i = 1'b1;
    #1;
    chk("rst_outputs", 32'({ram_re_o, ram_we_o, ram_select_o, ram_addr_o, rsp0_valid_o, rsp1_valid_o,
                            cfg_error_o, req0_ready_o, req1_ready_o}), 32'(0));
    chk("rst_wrdata", 32'(ram_wrdata_o), 32'(0));
    chk("rst_rddata", 32'(rsp_rddata_o), 32'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    m_reset();
  endtask

  task automatic req(input int id, input bit we, input int addr, input int wd);
    if (id == 0) begin
      req0_valid_i = 1'b1; req0_we_i = we; req0_addr_i = 15'(addr); req0_wrdata_i = 20'(wd);
    end else begin
      req1_valid_i = 1'b1; req1_we_i = we; req1_addr_i = 15'(addr); req1_wrdata_i = 20'(wd);
    end
  endtask

  initial begin
    int gr[4];
    rst_i = 1'b1; cfg_output_config_i = 3'd5; cfg_update_i = 1'b0;
    req0_valid_i = 0; req0_we_i = 0; req0_addr_i = 0; req0_wrdata_i = 0;
    req1_valid_i = 0; req1_we_i = 0; req1_addr_i = 0; req1_wrdata_i = 0;
    ram_rddata_i = 0; cyc = 0; last_grant = -1;
    m_reset();
    @(posedge clk_i);
    #1;
    do_reset();

    // Read at cfg 5 (20-bit): 0x0600 -> RAM 3, local 0.
    req(0, 0, 'h0600, 0);
    cycle();
    idle_reqs();
    chk("dir_read_re", 32'(ram_re_o), 32'(1));
    chk("dir_read_sel", 32'(ram_select_o), 32'(3));
    chk("dir_read_addr", 32'(ram_addr_o), 32'(0));
    cycle();
    ram_rddata_i = 20'hABCDE;
    cycle();
    chk("dir_rsp0", 32'(rsp0_valid_o), 32'(1));
    chk("dir_rsp_data", 32'(rsp_rddata_o), 32'hABCDE);
    repeat (2) cycle();

    // Switch to 1-bit config, then write 0x5ABC from requester 1.
    cfg_output_config_i = 3'd1; cfg_update_i = 1'b1;
    cycle();
    cfg_update_i = 1'b0;
    repeat (3) cycle();
    req(1, 1, 'h5ABC, 'h00001);
    cycle();
    idle_reqs();
    chk("dir_write_we", 32'(ram_we_o), 32'(1));
    chk("dir_write_sel", 32'(ram_select_o), 32'(2));
    chk("dir_write_addr", 32'(ram_addr_o), 32'h1ABC);
    chk("dir_write_data", 32'(ram_wrdata_o), 32'h00001);
    repeat (4) cycle();

    // Both requesters reading from reset: strict alternation.
    do_reset();
    req(0, 0, 'h0010, 0); req(1, 0, 'h0220, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      gr[i] = last_grant;
    end
    idle_reqs();
    chk("rr_seq", 32'({gr[0][1:0], gr[1][1:0], gr[2][1:0], gr[3][1:0]}), 32'b00_01_00_01);
    repeat (5) cycle();

    // Two back-to-back reads, update to cfg 3 right after: readies held until both responses drain.
    req(0, 0, 'h0001, 0);
    repeat (2) cycle();
    req(1, 0, 'h0002, 0);
    cfg_output_config_i = 3'd3; cfg_update_i = 1'b1;
    cycle();
    cfg_update_i = 1'b0;
    repeat (6) cycle();
    idle_reqs();
    req(0, 0, 'h1801, 0);
    cycle();
    idle_reqs();
    chk("cfg3_sel", 32'(ram_select_o), 32'(3));
    chk("cfg3_addr", 32'(ram_addr_o), 32'h001);
    repeat (4) cycle();

    // Illegal config 7 lands in ERR with requests pending, cfg 4 recovers.
    cfg_output_config_i = 3'd7; cfg_update_i = 1'b1;
    cycle();
    cfg_update_i = 1'b0;
    req(0, 0, 'h0100, 0); req(1, 1, 'h0200, 'h12345);
    repeat (4) cycle();
    #3;
    chk("err_flag", 32'(cfg_error_o), 32'(1));
    chk("err_ready", 32'({req0_ready_o, req1_ready_o}), 32'(0));
    #0;
    cfg_output_config_i = 3'd4; cfg_update_i = 1'b1;
    cycle();
    cfg_update_i = 1'b0;
    repeat (3) cycle();
    chk("err_cleared", 32'(cfg_error_o), 32'(0));
    repeat (4) cycle();
    idle_reqs();
    repeat (4) cycle();

    // Reset one cycle after a read handshake: that read never responds.
    req(0, 0, 'h0777, 0);
    cycle();
    do_reset();
    repeat (5) cycle();
    req(0, 0, 'h0600, 0); req(1, 0, 'h0000, 0);
    cycle();
    idle_reqs();
    chk("post_rst_grant", 32'(last_grant), 32'(0));
    chk("post_rst_sel", 32'(ram_select_o), 32'(3));
    repeat (4) cycle();

    // Random traffic with occasional config updates, including illegal ones.
    for (int k = 0; k < 600; k++) begin
      req0_valid_i = 1'($urandom_range(0, 3) != 0);
      req1_valid_i = 1'($urandom_range(0, 3) != 0);
      req0_we_i = 1'($urandom_range(0, 1));
      req1_we_i = 1'($urandom_range(0, 1));
      req0_addr_i = 15'($urandom);
      req1_addr_i = 15'($urandom);
      req0_wrdata_i = 20'($urandom);
      req1_wrdata_i = 20'($urandom);
      cfg_update_i = 1'($urandom_range(0, 29) == 0);
      cfg_output_config_i = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5));
      cycle();
    end
    idle_reqs();
    cfg_output_config_i = 3'd5; cfg_update_i = 1'b1;
    cycle();
    cfg_update_i = 1'b0;
    repeat (8) cycle();
    chk("final_mode_run", 32'(cfg_error_o), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpsram_port_arbiter.md
Name: dpsram_port_arbiter

Overview:
- Shares TDP port A0 of one 4x512x20 DPSRAM block (TDP non-split, 1–20 bit output configs) between two requesters.
- Round-robin arbitration; decodes flat address into ram_select plus RAM-local address from the active output config.
- Issues registered RAM strobes; tracks in-flight reads and steers read data from the read-data deselection output back to the issuing requester.
- Config changes drain the pipeline before taking effect.

Parameters:
- ADDR_W, 15, flat requester address width (32k x 1 max).
- DATA_W, 20, data width per RAM port.
- LOC_W, 13, RAM-local address width (8k x 1 per RAM max).

Ports:
- clk_i  in  1  clock; one clock; all flops on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- cfg_output_config_i  in  3  requested config: 1=1b, 2=2b, 3=5b, 4=10b, 5=20b.
- cfg_update_i  in  1  pulse; apply cfg_output_config_i after drain.
- cfg_error_o  out  1  high while in ERR.
- req0_valid_i / req1_valid_i  in  1  request valid.
- req0_ready_o / req1_ready_o  out  1  grant; handshake = valid & ready.
- req0_we_i / req1_we_i  in  1  1=write, 0=read.
- req0_addr_i / req1_addr_i  in  ADDR_W  flat address.
- req0_wrdata_i / req1_wrdata_i  in  DATA_W  right-aligned write data.
- rsp0_valid_o / rsp1_valid_o  out  1  read response strobe.
- rsp_rddata_o  out  DATA_W  read data, shared by both responses.
- ram_re_o  out  1  read enable to RAM port and deselection select regs.
- ram_we_o  out  1  write enable.
- ram_select_o  out  2  RAM select.
- ram_addr_o  out  LOC_W  right-aligned RAM-local address.
- ram_wrdata_o  out  DATA_W  write data.
- ram_rddata_i  in  DATA_W  a0 read data from the deselection stage.

Behaviour:
- Reset: state=RUN, cfg_q=5, rr_ptr=0. Outputs 0: all ram_*, all rsp*, rsp_rddata_o, cfg_error_o. In-flight pipeline cleared.
- States:
  - RUN: grants allowed.
  - DRAIN: no grants; wait until in-flight read pipeline is empty. Then load cfg_q from a latched copy of cfg_output_config_i captured at the update pulse. Legal values (1..5) go to RUN; others (0, 6, 7) go to ERR.
  - ERR: no grants, cfg_error_o=1. Left only by cfg_update_i, which goes to DRAIN.
- cfg_update_i in RUN or ERR moves to DRAIN next cycle. A handshake in the same cycle as the update still completes. cfg_update_i during DRAIN re-latches the value and keeps draining.
- Arbitration (RUN only):
  - Only valid requesters are granted, so ready depends combinationally on valid.
  - If only one valid, grant it. If both, grant rr_ptr.
  - After a grant to i, rr_ptr = ~i. At most one grant per cycle, so full throughput is one access/cycle.
- Decode: shift = 14 - cfg_q (13, 12, 11, 10, 9).
  - ram_select = addr >> shift, 2 bits.
  - ram_addr = addr & ((1<<shift)-1), zero-extended to LOC_W.
  - Address bits above shift+1 are ignored.
- Timing, handshake in cycle T:
  - T+1: ram_re_o/ram_we_o pulse for one cycle, with ram_select_o, ram_addr_o, ram_wrdata_o registered. ram_wrdata_o holds its value when idle.
  - Reads: ram_rddata_i is valid in T+2. It is registered at the end of T+2, so rsp{id}_valid_o=1 and rsp_rddata_o are presented in T+3. Read latency is 3 cycles.
  - rsp_rddata_o holds its last value otherwise.
- Writes produce no response.
- In-flight tracking: 2-stage shift of {valid, id}; DRAIN waits until both stages and the response register are empty.
- Reset mid-operation discards in-flight reads; no response is ever produced for them.

Decomposition:
- Package dpsram_ctrl_pkg:
  - CONFIG_1BIT..CONFIG_20BIT constants (3'd1..3'd5).
  - State enum {RUN, DRAIN, ERR}.
  - Function cfg_to_shift(cfg).
  - Function cfg_is_legal(cfg).
- Sub-module rr_arbiter2: 2-way round-robin grant with rr_ptr, inputs valid[1:0] and enable, output one-hot grant.

Test Plan:
- Reset then cfg=5. req0 read addr 0x0600 → T+1: ram_re_o=1, ram_select_o=3, ram_addr_o=0x000. Drive ram_rddata_i=0xABCDE in T+2 → T+3: rsp0_valid_o=1, rsp_rddata_o=0xABCDE.
- cfg_update_i with cfg=1, then req1 write addr 0x5ABC data 0x00001 → ram_we_o=1, ram_select_o=2, ram_addr_o=0x1ABC, ram_wrdata_o=0x00001; no rsp.
- Both valid continuously for 4 cycles from reset → grants 0,1,0,1. rsp0/rsp1 alternate 3 cycles after each read grant; never both in one cycle.
- Two reads back-to-back, then cfg_update_i (cfg=3) in the cycle after the second handshake → ready low until both responses are seen. Then RUN; addr 0x1801 decodes to select 3, addr 0x001.
- cfg_update_i with cfg=7 → after drain cfg_error_o=1 and readies stay 0 with requests pending. Then cfg_update_i with cfg=4 → cfg_error_o=0 and grants resume.
- Assert rst_i one cycle after a read handshake → all outputs 0 immediately. No rsp for that read; rr_ptr=0, cfg=5 afterwards.
